// File: rtl/tt_um_hoene_frame_controller.sv
// -----------------------------------------------------------------------------
// tt_um_hoene_frame_controller
//
// Frame sequencer for the smart LED chain. Takes the decoded bit stream from
// the sync stage and walks one frame: address, command, RGB payload and, when
// built with PARITY_EN defined, a trailing even-parity bit. Colour values reach
// the LED registers only when a frame is addressed to this device (or is a
// broadcast) and completes without error.
//
// Build option: define PARITY_EN to append and check one even-parity bit.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   in_clk       one-cycle bit strobe, in_data valid in the same cycle
//   in_data      decoded bit, MSB-first
//   in_sync      high while the decoder is locked to a frame
//   in_error     decoder error, sampled every cycle
//   dev_addr     device address, latched at frame start
//   led_red/green/blue  committed colour values
//   update       one-cycle pulse when the led_* registers change
//   busy         high whenever the FSM is not idle
//   frame_error  sticky error flag, cleared at the next frame start
//   state        current FSM state (debug)
// -----------------------------------------------------------------------------
module tt_um_hoene_frame_controller #(
  parameter int ADDR_W  = 6,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_clk,
  input  logic               in_data,
  input  logic               in_sync,
  input  logic               in_error,
  input  logic [ADDR_W-1:0]  dev_addr,
  output logic [COLOR_W-1:0] led_red,
  output logic [COLOR_W-1:0] led_green,
  output logic [COLOR_W-1:0] led_blue,
  output logic               update,
  output logic               busy,
  output logic               frame_error,
  output logic [2:0]         state
);

  localparam int PAY_W = 3 * COLOR_W;
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_W - 1);
  localparam logic [4:0] CMD_LAST  = 5'd1;
  localparam logic [4:0] PAY_LAST  = 5'(PAY_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_CMD     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_COMMIT  = 3'd5,
    ST_WAIT    = 3'd6
  } state_t;

  // State that follows the last command/payload bit.
`ifdef PARITY_EN
  localparam state_t ST_TAIL = ST_PARITY;
`else
  localparam state_t ST_TAIL = ST_COMMIT;
`endif

  // Running even-parity accumulator step.
  function automatic logic parity_acc(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  // Commands that carry an RGB payload (SET and SET_BCAST).
  function automatic logic is_payload_cmd(input logic [1:0] cmd);
    return (cmd == 2'b01) || (cmd == 2'b10);
  endfunction

  state_t               state_r;
  state_t               state_next_s;
  logic                 busy_r;
  logic [ADDR_W-1:0]    dev_addr_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [1:0]           cmd_r;
  logic [PAY_W-1:0]     shadow_r;
  logic [4:0]           bit_cnt_r;
  logic                 frame_error_r;
  logic [COLOR_W-1:0]   led_red_r;
  logic [COLOR_W-1:0]   led_green_r;
  logic [COLOR_W-1:0]   led_blue_r;
  logic                 update_r;
`ifdef PARITY_EN
  logic                 par_r;
  logic                 parity_bad_s;
`endif

  logic in_field_s;
  logic field_last_s;
  logic start_s;
  logic commit_s;
  logic bit_ok_s;
  logic abort_s;
  logic err_s;
  logic shift_s;
  logic match_s;

  // State register; busy tracks the registered state so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
    end
  end

  // Next-state logic: errors take priority over a bit strobe in the same cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_sync) state_next_s = ST_ADDR;
        else         state_next_s = ST_IDLE;
      end
      ST_ADDR, ST_CMD, ST_PAYLOAD, ST_PARITY: begin
        if (err_s) begin
          state_next_s = ST_WAIT;
        end else if (shift_s && field_last_s) begin
          case (state_r)
            ST_ADDR:    state_next_s = ST_CMD;
            ST_CMD: begin
              if (is_payload_cmd({cmd_r[0], in_data})) state_next_s = ST_PAYLOAD;
              else                                     state_next_s = ST_TAIL;
            end
            ST_PAYLOAD: state_next_s = ST_TAIL;
            ST_PARITY:  state_next_s = ST_COMMIT;
            default:    state_next_s = ST_WAIT;
          endcase
        end else begin
          state_next_s = state_r;
        end
      end
      ST_COMMIT: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (!in_sync) state_next_s = ST_IDLE;
        else          state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output/control decode: field bookkeeping, error detection and commit match.
  always_comb begin
    in_field_s   = 1'b0;
    field_last_s = 1'b0;
    start_s      = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE:    start_s = in_sync;
      ST_ADDR: begin
        in_field_s   = 1'b1;
        field_last_s = (bit_cnt_r == ADDR_LAST);
      end
      ST_CMD: begin
        in_field_s   = 1'b1;
        field_last_s = (bit_cnt_r == CMD_LAST);
      end
      ST_PAYLOAD: begin
        in_field_s   = 1'b1;
        field_last_s = (bit_cnt_r == PAY_LAST);
      end
      ST_PARITY: begin
        in_field_s   = 1'b1;
        field_last_s = 1'b1;
      end
      ST_COMMIT:  commit_s = 1'b1;
      default:    commit_s = 1'b0;
    endcase
    bit_ok_s = in_clk & in_sync & ~in_error;
    abort_s  = in_field_s & (in_error | ~in_sync);
`ifdef PARITY_EN
    // Even parity: accumulated frame bits XOR the P bit must be zero.
    parity_bad_s = (state_r == ST_PARITY) & bit_ok_s & parity_acc(par_r, in_data);
    err_s        = abort_s | parity_bad_s;
`else
    err_s        = abort_s;
`endif
    shift_s = in_field_s & bit_ok_s & ~err_s;
    match_s = (addr_r == dev_addr_r) || (cmd_r == 2'b10);
  end

  // Frame capture: address latch, field shift registers, bit counter, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_addr_r    <= {ADDR_W{1'b0}};
      addr_r        <= {ADDR_W{1'b0}};
      cmd_r         <= 2'b00;
      shadow_r      <= {PAY_W{1'b0}};
      bit_cnt_r     <= 5'd0;
      frame_error_r <= 1'b0;
`ifdef PARITY_EN
      par_r         <= 1'b0;
`endif
    end else if (start_s) begin
      dev_addr_r    <= dev_addr;
      bit_cnt_r     <= 5'd0;
      frame_error_r <= 1'b0;
`ifdef PARITY_EN
      par_r         <= 1'b0;
`endif
    end else if (err_s) begin
      frame_error_r <= 1'b1;
      bit_cnt_r     <= 5'd0;
    end else if (shift_s) begin
`ifdef PARITY_EN
      par_r <= parity_acc(par_r, in_data);
`endif
      if (field_last_s) bit_cnt_r <= 5'd0;
      else              bit_cnt_r <= bit_cnt_r + 5'd1;
      case (state_r)
        ST_ADDR:    addr_r   <= {addr_r[ADDR_W-2:0], in_data};
        ST_CMD:     cmd_r    <= {cmd_r[0], in_data};
        ST_PAYLOAD: shadow_r <= {shadow_r[PAY_W-2:0], in_data};
        default:    cmd_r    <= cmd_r;
      endcase
    end
  end

  // Commit: the LED registers only ever load a complete shadow word or zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_red_r   <= {COLOR_W{1'b0}};
      led_green_r <= {COLOR_W{1'b0}};
      led_blue_r  <= {COLOR_W{1'b0}};
      update_r    <= 1'b0;
    end else if (commit_s && match_s && is_payload_cmd(cmd_r)) begin
      led_red_r   <= shadow_r[PAY_W-1 -: COLOR_W];
      led_green_r <= shadow_r[2*COLOR_W-1 -: COLOR_W];
      led_blue_r  <= shadow_r[COLOR_W-1:0];
      update_r    <= 1'b1;
    end else if (commit_s && match_s && (cmd_r == 2'b11)) begin
      led_red_r   <= {COLOR_W{1'b0}};
      led_green_r <= {COLOR_W{1'b0}};
      led_blue_r  <= {COLOR_W{1'b0}};
      update_r    <= 1'b1;
    end else begin
      update_r    <= 1'b0;
    end
  end

  assign led_red     = led_red_r;
  assign led_green   = led_green_r;
  assign led_blue    = led_blue_r;
  assign update      = update_r;
  assign busy        = busy_r;
  assign frame_error = frame_error_r;
  assign state       = state_r;

endmodule

// File: tb/tb_tt_um_hoene_frame_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tt_um_hoene_frame_controller. Frames are built as bit
// queues from their fields; a reference model applies the addressing/command
// rules to predict the LED registers and the update pulse.
// -----------------------------------------------------------------------------
module tb_tt_um_hoene_frame_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_clk = 1'b0;
  logic       in_data = 1'b0;
  logic       in_sync = 1'b0;
  logic       in_error = 1'b0;
  logic [5:0] dev_addr = 6'h00;
  logic [7:0] led_red, led_green, led_blue;
  logic       update, busy, frame_error;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  logic [7:0] exp_r = 8'h00, exp_g = 8'h00, exp_b = 8'h00;
  bit frame_q[$];

  tt_um_hoene_frame_controller dut (
    .clk(clk), .rst_n(rst_n), .in_clk(in_clk), .in_data(in_data),
    .in_sync(in_sync), .in_error(in_error), .dev_addr(dev_addr),
    .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
    .update(update), .busy(busy), .frame_error(frame_error), .state(state)
  );

  always #5 clk = ~clk;

  // Count cycles in which update was high.
  always @(posedge clk) if (update === 1'b1) upd_cnt++;

  // Reference model: predicted LED contents after a frame.
  task automatic model_frame(input logic [5:0] dev, input logic [5:0] a, input logic [1:0] c,
                             input logic [23:0] rgb, input bit bad, output bit upd);
    bit hit;
    hit = (a == dev) || (c == 2'b10);
    upd = 1'b0;
    if (!bad && hit && c != 2'b00) begin
      upd = 1'b1;
      if (c == 2'b11) {exp_r, exp_g, exp_b} = 24'h000000;
      else            {exp_r, exp_g, exp_b} = rgb;
    end
  endtask

  task automatic build_frame(input logic [5:0] a, input logic [1:0] c, input logic [23:0] rgb);
`ifdef PARITY_EN
    bit p;
`endif
    frame_q.delete();
    for (int i = 5; i >= 0; i--) frame_q.push_back(a[i]);
    frame_q.push_back(c[1]);
    frame_q.push_back(c[0]);
    if (c == 2'b01 || c == 2'b10)
      for (int i = 23; i >= 0; i--) frame_q.push_back(rgb[i]);
`ifdef PARITY_EN
    p = 1'b0;
    foreach (frame_q[i]) p ^= frame_q[i];
    frame_q.push_back(p);
`endif
  endtask

  task automatic start_frame(input logic [5:0] dev);
    dev_addr = dev;
    in_sync  = 1'b1;
    @(negedge clk);
  endtask

  // Drives frame_q; returns at the negedge right after the last strobe's edge.
  task automatic drive_bits(input int err_idx);
    for (int i = 0; i < frame_q.size(); i++) begin
      in_clk   = 1'b1;
      in_data  = frame_q[i];
      in_error = (i == err_idx);
      @(negedge clk);
      in_clk   = 1'b0;
      in_error = 1'b0;
      in_data  = 1'b0;
      if (i != frame_q.size() - 1) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    in_sync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({led_red, led_green, led_blue, update, busy, frame_error, state} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {led_red, led_green, led_blue, update, busy, frame_error, state});
    end
    rst_n = 1'b1;
    @(negedge clk);
    in_clk = 1'b1; in_data = 1'b1;
    @(negedge clk);
    in_clk = 1'b0; in_data = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobe_ignored got state %0d busy %b want 0 0", state, busy);
    end
  endtask

  task automatic test_set();
    bit upd;
    build_frame(6'h05, 2'b01, 24'h123456);
    model_frame(6'h05, 6'h05, 2'b01, 24'h123456, 1'b0, upd);
    start_frame(6'h05);
    dev_addr = 6'h00;   // must not matter: address was latched at frame start
    drive_bits(-1);
    checks++;
    if (state !== 3'd5 || update !== 1'b0 || {led_red, led_green, led_blue} !== 24'h000000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL set_latency got st %0d upd %b leds %h busy %b want 5 0 000000 1",
               state, update, {led_red, led_green, led_blue}, busy);
    end
    in_sync = 1'b0;     // sync falling right after the final bit is legal
    @(negedge clk);
    checks++;
    if ({led_red, led_green, led_blue} !== 24'h123456 || update !== 1'b1) begin
      errors++;
      $display("FAIL set_commit got leds %h upd %b want 123456 1", {led_red, led_green, led_blue}, update);
    end
    checks++;
    if (state !== 3'd6 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL set_wait got st %0d ferr %b want 6 0", state, frame_error);
    end
    @(negedge clk);
    checks++;
    if (update !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL set_pulse_end got upd %b st %0d busy %b want 0 0 0", update, state, busy);
    end
  endtask

  task automatic test_no_match();
    int u0;
    u0 = upd_cnt;
    build_frame(6'h06, 2'b01, 24'hFFFFFF);
    start_frame(6'h05);
    drive_bits(-1);
    @(negedge clk);
    checks++;
    if (state !== 3'd6 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL nomatch_wait got st %0d ferr %b want 6 0", state, frame_error);
    end
    end_frame();
    checks++;
    if ({led_red, led_green, led_blue} !== {exp_r, exp_g, exp_b} || upd_cnt != u0 || state !== 3'd0) begin
      errors++;
      $display("FAIL nomatch_result got leds %h upds %0d st %0d want %h 0 0",
               {led_red, led_green, led_blue}, upd_cnt - u0, state, {exp_r, exp_g, exp_b});
    end
  endtask

  task automatic test_bcast_clear();
    bit upd;
    build_frame(6'h3F, 2'b10, 24'hAABBCC);
    model_frame(6'h05, 6'h3F, 2'b10, 24'hAABBCC, 1'b0, upd);
    start_frame(6'h05);
    drive_bits(-1);
    @(negedge clk);
    checks++;
    if ({led_red, led_green, led_blue} !== 24'hAABBCC || update !== upd) begin
      errors++;
      $display("FAIL bcast got leds %h upd %b want aabbcc 1", {led_red, led_green, led_blue}, update);
    end
    end_frame();
    build_frame(6'h05, 2'b11, 24'h0);
    model_frame(6'h05, 6'h05, 2'b11, 24'h0, 1'b0, upd);
    start_frame(6'h05);
    drive_bits(-1);
    @(negedge clk);
    checks++;
    if ({led_red, led_green, led_blue} !== 24'h000000 || update !== 1'b1) begin
      errors++;
      $display("FAIL clear got leds %h upd %b want 000000 1", {led_red, led_green, led_blue}, update);
    end
    end_frame();
  endtask

  task automatic test_error();
    int u0;
    bit upd;
    logic [23:0] rgb;
    rgb = 24'($urandom);
    u0 = upd_cnt;
    build_frame(6'h05, 2'b01, rgb);
    start_frame(6'h05);
    drive_bits(9);
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd6 || frame_error !== 1'b1 || {led_red, led_green, led_blue} !== {exp_r, exp_g, exp_b}) begin
      errors++;
      $display("FAIL err_wait got st %0d ferr %b leds %h want 6 1 %h",
               state, frame_error, {led_red, led_green, led_blue}, {exp_r, exp_g, exp_b});
    end
    end_frame();
    checks++;
    if (frame_error !== 1'b1 || state !== 3'd0 || upd_cnt != u0) begin
      errors++;
      $display("FAIL err_sticky got ferr %b st %0d upds %0d want 1 0 0", frame_error, state, upd_cnt - u0);
    end
    model_frame(6'h05, 6'h05, 2'b01, rgb, 1'b0, upd);
    start_frame(6'h05);
    checks++;
    if (frame_error !== 1'b0 || state !== 3'd1) begin
      errors++;
      $display("FAIL err_cleared got ferr %b st %0d want 0 1", frame_error, state);
    end
    drive_bits(-1);
    @(negedge clk);
    checks++;
    if ({led_red, led_green, led_blue} !== rgb || update !== 1'b1) begin
      errors++;
      $display("FAIL err_recover got leds %h upd %b want %h 1", {led_red, led_green, led_blue}, update, rgb);
    end
    end_frame();
  endtask

  task automatic test_sync_loss();
    int u0;
    u0 = upd_cnt;
    build_frame(6'h05, 2'b01, 24'h0F0F0F);
    while (frame_q.size() > 12) void'(frame_q.pop_back());
    start_frame(6'h05);
    drive_bits(-1);
    in_sync = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd6 || frame_error !== 1'b1) begin
      errors++;
      $display("FAIL syncloss_err got st %0d ferr %b want 6 1", state, frame_error);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || {led_red, led_green, led_blue} !== {exp_r, exp_g, exp_b} || upd_cnt != u0) begin
      errors++;
      $display("FAIL syncloss_idle got st %0d leds %h upds %0d want 0 %h 0",
               state, {led_red, led_green, led_blue}, upd_cnt - u0, {exp_r, exp_g, exp_b});
    end
  endtask

  task automatic test_reset_midframe();
    bit upd;
    logic [23:0] rgb;
    build_frame(6'h21, 2'b10, 24'h5A5A5A);
    model_frame(6'h05, 6'h21, 2'b10, 24'h5A5A5A, 1'b0, upd);
    start_frame(6'h05);
    drive_bits(-1);
    end_frame();
    build_frame(6'h05, 2'b01, 24'hC3C3C3);
    while (frame_q.size() > 19) void'(frame_q.pop_back());
    start_frame(6'h05);
    drive_bits(-1);
    in_clk = 1'b1; in_data = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led_red, led_green, led_blue, update, busy, frame_error, state} !== 30'h0) begin
      errors++;
      $display("FAIL midreset_async got %h want 0", {led_red, led_green, led_blue, update, busy, frame_error, state});
    end
    {exp_r, exp_g, exp_b} = 24'h000000;
    @(negedge clk);
    in_clk = 1'b0; in_data = 1'b0; in_sync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rgb = 24'($urandom);
    build_frame(6'h05, 2'b01, rgb);
    model_frame(6'h05, 6'h05, 2'b01, rgb, 1'b0, upd);
    start_frame(6'h05);
    drive_bits(-1);
    @(negedge clk);
    checks++;
    if ({led_red, led_green, led_blue} !== rgb || update !== 1'b1) begin
      errors++;
      $display("FAIL midreset_next got leds %h upd %b want %h 1", {led_red, led_green, led_blue}, update, rgb);
    end
    end_frame();
  endtask

  task automatic test_random();
    logic [5:0] d, a;
    logic [1:0] c;
    logic [23:0] rgb;
    int err, u0;
    bit bad, upd;
    for (int n = 0; n < 20; n++) begin
      d   = 6'($urandom);
      a   = ($urandom_range(0, 1) == 1) ? d : 6'($urandom);
      c   = 2'($urandom_range(0, 3));
      rgb = 24'($urandom);
      build_frame(a, c, rgb);
      err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, frame_q.size() - 1)) : -1;
      bad = (err >= 0);
`ifdef PARITY_EN
      if (!bad && $urandom_range(0, 4) == 0) begin
        frame_q[frame_q.size() - 1] = ~frame_q[frame_q.size() - 1];
        bad = 1'b1;
      end
`endif
      model_frame(d, a, c, rgb, bad, upd);
      u0 = upd_cnt;
      start_frame(d);
      drive_bits(err);
      if (!bad) begin
        checks++;
        if (state !== 3'd5) begin
          errors++;
          $display("FAIL rand%0d_commit_state got %0d want 5", n, state);
        end
      end
      @(negedge clk);
      checks++;
      if ({led_red, led_green, led_blue} !== {exp_r, exp_g, exp_b} || update !== upd || frame_error !== bad) begin
        errors++;
        $display("FAIL rand%0d got leds %h upd %b ferr %b want %h %b %b (a %h d %h c %0d err %0d)",
                 n, {led_red, led_green, led_blue}, update, frame_error, {exp_r, exp_g, exp_b},
                 upd, bad, a, d, c, err);
      end
      end_frame();
      checks++;
      if (upd_cnt - u0 != int'(upd)) begin
        errors++;
        $display("FAIL rand%0d_pulses got %0d want %0d", n, upd_cnt - u0, int'(upd));
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    int u0;
    bit upd;
    build_frame(6'h05, 2'b01, 24'h123456);
    model_frame(6'h05, 6'h05, 2'b01, 24'h123456, 1'b0, upd);
    start_frame(6'h05);
    drive_bits(-1);
    @(negedge clk);
    checks++;
    if ({led_red, led_green, led_blue} !== 24'h123456 || update !== 1'b1) begin
      errors++;
      $display("FAIL parity_ok got leds %h upd %b want 123456 1", {led_red, led_green, led_blue}, update);
    end
    end_frame();
    build_frame(6'h05, 2'b01, 24'h654321);
    frame_q[frame_q.size() - 1] = ~frame_q[frame_q.size() - 1];
    u0 = upd_cnt;
    start_frame(6'h05);
    drive_bits(-1);
    @(negedge clk);
    checks++;
    if (frame_error !== 1'b1 || {led_red, led_green, led_blue} !== 24'h123456) begin
      errors++;
      $display("FAIL parity_bad got ferr %b leds %h want 1 123456", frame_error, {led_red, led_green, led_blue});
    end
    end_frame();
    checks++;
    if (upd_cnt != u0) begin
      errors++;
      $display("FAIL parity_bad_pulse got %0d want 0", upd_cnt - u0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_set();
    test_no_match();
    test_bcast_clear();
    test_error();
    test_sync_loss();
    test_reset_midframe();
    test_random();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
